// File: rtl/i2c_target.sv
// I2C target for the PWM register bank.
// Protocol: address byte, register pointer byte, then data bytes. The
// pointer auto-increments after each data byte written or read-ACKed.
// SDA is open-drain: this block only ever pulls low or releases.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus free or after STOP
// ADDR      | shifting in the address byte
// ADDR_ACK  | address matched, ACKing on the 9th clock
// PTR       | shifting in the register pointer byte
// PTR_ACK   | ACKing the pointer byte
// WDATA     | shifting in a write data byte
// WDATA_ACK | ACKing a write data byte
// RDATA     | shifting a read byte out, MSB first
// RDATA_ACK | sampling the master's ACK/NACK; parks here after NACK
// IGNORE    | transaction for another target, wait for START/STOP
module i2c_target #(
    parameter logic [6:0] ADDRESS     = 7'h40,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    inout  wire        sda_io,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] ADDR      = 4'd1;
    localparam logic [3:0] ADDR_ACK  = 4'd2;
    localparam logic [3:0] PTR       = 4'd3;
    localparam logic [3:0] PTR_ACK   = 4'd4;
    localparam logic [3:0] WDATA     = 4'd5;
    localparam logic [3:0] WDATA_ACK = 4'd6;
    localparam logic [3:0] RDATA     = 4'd7;
    localparam logic [3:0] RDATA_ACK = 4'd8;
    localparam logic [3:0] IGNORE    = 4'd9;

    logic [SYNC_N-1:0] scl_sync_q;
    logic [SYNC_N-1:0] sda_sync_q;
    logic              scl_prev_q;
    logic              sda_prev_q;
    logic              scl_s;
    logic              sda_s;
    logic              scl_rise;
    logic              scl_fall;
    logic              start_det;
    logic              stop_det;

    logic [3:0] state_q,    state_d;
    logic [3:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] shift_q,    shift_d;
    logic       sda_oe_q,   sda_oe_d;
    logic       rw_q,       rw_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] wdata_q,    wdata_d;
    logic       we_q,       we_d;
    logic       busy_q,     busy_d;

    // Synchronize the bus lines and keep the previous synchronized value for edge detection.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_N-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_N-2:0], sda_io};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_N-1];
    assign sda_s     = sda_sync_q[SYNC_N-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // Protocol FSM: next-state, shift register, pointer and SDA drive decisions.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        rw_d       = rw_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            IDLE, IGNORE: begin
            end

            ADDR: begin
                if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[6:0] == ADDRESS) begin
                            state_d = ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = sda_s;
                        end else begin
                            state_d = IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end

            // ACK phases: bit_cnt 0 = waiting for the 8th fall, 1 = ACK driven,
            // 2 = ACK clock seen high, next fall ends it.
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                if (scl_fall && bit_cnt_q == 4'd0) begin
                    sda_oe_d  = 1'b1;
                    bit_cnt_d = 4'd1;
                end else if (scl_rise && bit_cnt_q == 4'd1) begin
                    bit_cnt_d = 4'd2;
                end else if (scl_fall && bit_cnt_q == 4'd2) begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = 4'd0;
                    if (state_q == ADDR_ACK && rw_q) begin
                        state_d  = RDATA;
                        shift_d  = reg_rdata_i;
                        sda_oe_d = ~reg_rdata_i[7];
                    end else if (state_q == ADDR_ACK) begin
                        state_d = PTR;
                    end else begin
                        state_d = WDATA;
                    end
                end
            end

            PTR: begin
                if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        reg_addr_d = {shift_q[6:0], sda_s};
                        state_d    = PTR_ACK;
                        bit_cnt_d  = 4'd0;
                    end
                end
            end

            WDATA: begin
                if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        wdata_d   = {shift_q[6:0], sda_s};
                        we_d      = 1'b1;
                        state_d   = WDATA_ACK;
                        bit_cnt_d = 4'd0;
                    end
                end
            end

            RDATA: begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b0;
                        state_d   = RDATA_ACK;
                        bit_cnt_d = 4'd0;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
            end

            // bit_cnt 0 = waiting for the master's bit, 1 = ACKed, 2 = NACKed (parked).
            RDATA_ACK: begin
                if (scl_rise && bit_cnt_q == 4'd0) begin
                    if (!sda_s) begin
                        reg_addr_d = reg_addr_q + 8'd1;
                        bit_cnt_d  = 4'd1;
                    end else begin
                        bit_cnt_d  = 4'd2;
                    end
                end else if (scl_fall && bit_cnt_q == 4'd1) begin
                    shift_d   = reg_rdata_i;
                    sda_oe_d  = ~reg_rdata_i[7];
                    state_d   = RDATA;
                    bit_cnt_d = 4'd0;
                end
            end

            default: begin
                state_d   = IDLE;
                bit_cnt_d = 4'd0;
                sda_oe_d  = 1'b0;
            end
        endcase

        // The pointer advances the cycle after a write strobe, so the strobe
        // itself always sees the address it was written to.
        if (we_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
        end

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            sda_oe_q   <= 1'b0;
            rw_q       <= 1'b0;
            reg_addr_q <= 8'd0;
            wdata_q    <= 8'd0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            rw_q       <= rw_d;
            reg_addr_q <= reg_addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_io      = sda_oe_q ? 1'b0 : 1'bz;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_we_o    = we_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C master, register file
// modelled as reg_rdata_i = reg_addr_o ^ 0xA5, write strobes logged.
module tb_i2c_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m_low = 1'b0;
    wire        sda_bus;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_we_o;
    logic [7:0] reg_rdata_i;
    logic       busy_o;

    int         n_assert = 0;
    int         n_fail = 0;

    int         we_cnt = 0;
    logic [7:0] we_a [0:15];
    logic [7:0] we_dv [0:15];
    logic       target_drove = 1'b0;
    logic       busy_seen = 1'b0;

    assign sda_bus = sda_m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);
    assign reg_rdata_i = reg_addr_o ^ 8'hA5;

    always #5 clk = ~clk;

    i2c_target #(.ADDRESS(7'h40), .SYNC_STAGES(2)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .scl_i      (scl),
        .sda_io     (sda_bus),
        .reg_addr_o (reg_addr_o),
        .reg_wdata_o(reg_wdata_o),
        .reg_we_o   (reg_we_o),
        .reg_rdata_i(reg_rdata_i),
        .busy_o     (busy_o)
    );

    always @(negedge clk) begin
        if (reg_we_o) begin
            if (we_cnt < 16) begin
                we_a[we_cnt]  = reg_addr_o;
                we_dv[we_cnt] = reg_wdata_o;
            end
            we_cnt = we_cnt + 1;
        end
        if (!sda_m_low && sda_bus == 1'b0) target_drove = 1'b1;
        if (busy_o) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_start();
        sda_m_low = 1'b0; wc(Q);
        scl = 1'b1;       wc(Q);
        sda_m_low = 1'b1; wc(Q);
        scl = 1'b0;       wc(Q);
    endtask

    task automatic m_stop();
        sda_m_low = 1'b1; wc(Q);
        scl = 1'b1;       wc(Q);
        sda_m_low = 1'b0; wc(Q);
    endtask

    task automatic m_wbit(input logic b);
        sda_m_low = ~b; wc(Q);
        scl = 1'b1;     wc(2 * Q);
        scl = 1'b0;     wc(Q);
    endtask

    task automatic m_rbit(output logic b);
        sda_m_low = 1'b0; wc(Q);
        scl = 1'b1;       wc(Q);
        b = sda_bus;      wc(Q);
        scl = 1'b0;       wc(Q);
    endtask

    task automatic m_wbyte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) m_wbit(d[i]);
        m_rbit(b);
        ack = ~b;
    endtask

    task automatic m_rbyte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            m_rbit(b);
            d[i] = b;
        end
        m_wbit(~ack);
    endtask

    initial begin
        logic       a0, a1, a2;
        logic [7:0] rd;
        logic       b;

        // Reset state
        wc(4);
        chk("rst_addr", reg_addr_o, 8'h00);
        chk("rst_wdata", reg_wdata_o, 8'h00);
        chk("rst_we", reg_we_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_sda", sda_bus, 1'b1);
        rst_ni = 1'b1;
        wc(Q);

        // Single write
        we_cnt = 0;
        m_start();
        m_wbyte(8'h80, a0);
        chk("w1_busy_mid", busy_o, 1'b1);
        m_wbyte(8'h0F, a1);
        m_wbyte(8'h55, a2);
        m_stop();
        wc(Q);
        chk("w1_ack_addr", a0, 1'b1);
        chk("w1_ack_ptr", a1, 1'b1);
        chk("w1_ack_data", a2, 1'b1);
        chk("w1_we_cnt", we_cnt, 1);
        chk("w1_we_addr", we_a[0], 8'h0F);
        chk("w1_we_data", we_dv[0], 8'h55);
        chk("w1_ptr_after", reg_addr_o, 8'h10);
        chk("w1_busy_after", busy_o, 1'b0);

        // Burst write across the pointer wrap
        we_cnt = 0;
        m_start();
        m_wbyte(8'h80, a0);
        m_wbyte(8'hFE, a1);
        m_wbyte(8'h11, a2);
        m_wbyte(8'h22, a2);
        m_wbyte(8'h33, a2);
        m_stop();
        wc(Q);
        chk("bw_we_cnt", we_cnt, 3);
        chk("bw_a0", we_a[0], 8'hFE);
        chk("bw_d0", we_dv[0], 8'h11);
        chk("bw_a1", we_a[1], 8'hFF);
        chk("bw_d1", we_dv[1], 8'h22);
        chk("bw_a2", we_a[2], 8'h00);
        chk("bw_d2", we_dv[2], 8'h33);
        chk("bw_ptr_after", reg_addr_o, 8'h01);

        // Combined read: pointer 0x06, repeated start, two bytes
        we_cnt = 0;
        m_start();
        m_wbyte(8'h80, a0);
        m_wbyte(8'h06, a1);
        m_start();
        m_wbyte(8'h81, a2);
        chk("rd_ack_rdaddr", a2, 1'b1);
        m_rbyte(rd, 1'b1);
        chk("rd_byte0", rd, 8'hA3);
        m_rbyte(rd, 1'b0);
        chk("rd_byte1", rd, 8'hA2);
        wc(Q);
        chk("rd_sda_released", sda_bus, 1'b1);
        chk("rd_ptr", reg_addr_o, 8'h07);
        m_stop();
        wc(Q);
        chk("rd_no_we", we_cnt, 0);
        chk("rd_ptr_after_stop", reg_addr_o, 8'h07);

        // Wrong address
        we_cnt = 0;
        target_drove = 1'b0;
        busy_seen = 1'b0;
        m_start();
        m_wbyte(8'h82, a0);
        m_wbyte(8'h00, a1);
        m_wbyte(8'h12, a2);
        m_stop();
        wc(Q);
        chk("wa_nack_addr", a0, 1'b0);
        chk("wa_sda_never_low", target_drove, 1'b0);
        chk("wa_no_we", we_cnt, 0);
        chk("wa_busy_never", busy_seen, 1'b0);
        chk("wa_ptr_kept", reg_addr_o, 8'h07);

        // STOP after 4 data bits, then a normal write to the same pointer
        we_cnt = 0;
        m_start();
        m_wbyte(8'h80, a0);
        m_wbyte(8'h20, a1);
        m_wbit(1'b1);
        m_wbit(1'b0);
        m_wbit(1'b1);
        m_wbit(1'b1);
        m_stop();
        wc(Q);
        chk("ps_no_we", we_cnt, 0);
        chk("ps_ptr", reg_addr_o, 8'h20);
        chk("ps_busy", busy_o, 1'b0);
        m_start();
        m_wbyte(8'h80, a0);
        m_wbyte(8'h20, a1);
        m_wbyte(8'h5A, a2);
        m_stop();
        wc(Q);
        chk("ps2_ack_data", a2, 1'b1);
        chk("ps2_we_cnt", we_cnt, 1);
        chk("ps2_we_addr", we_a[0], 8'h20);
        chk("ps2_we_data", we_dv[0], 8'h5A);
        chk("ps2_ptr", reg_addr_o, 8'h21);

        // Reset while the target is pulling SDA low during a read (0x10 ^ 0xA5 = 0xB5)
        m_start();
        m_wbyte(8'h80, a0);
        m_wbyte(8'h10, a1);
        m_start();
        m_wbyte(8'h81, a2);
        m_rbit(b);
        chk("mr_bit7", b, 1'b1);
        wc(Q);
        scl = 1'b1;
        wc(Q);
        chk("mr_target_low", sda_bus, 1'b0);
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_sda_released", sda_bus, 1'b1);
        chk("mr_ptr", reg_addr_o, 8'h00);
        chk("mr_busy", busy_o, 1'b0);
        wc(2);
        rst_ni = 1'b1;
        wc(Q);
        we_cnt = 0;
        m_start();
        m_wbyte(8'h80, a0);
        m_wbyte(8'h33, a1);
        m_wbyte(8'h77, a2);
        m_stop();
        wc(Q);
        chk("mr2_ack_addr", a0, 1'b1);
        chk("mr2_ack_data", a2, 1'b1);
        chk("mr2_we_cnt", we_cnt, 1);
        chk("mr2_we_addr", we_a[0], 8'h33);
        chk("mr2_we_data", we_dv[0], 8'h77);
        chk("mr2_ptr", reg_addr_o, 8'h34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
